// File: rtl/qam_pkg.sv
// Shared constants, reference tables and symbol mapping for the 4-QAM link.
package qam_pkg;

    localparam int unsigned SPS      = 8;
    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned REF_W    = 8;
    localparam int unsigned REF_FS   = 127;

    // Which carrier reference a correlator multiplies against.
    typedef enum logic {
        REF_COS = 1'b0,
        REF_SIN = 1'b1
    } ref_sel_e;

    // Symbol bit value that maps to the negative amplitude (-A); the other maps to +A.
    localparam logic MAP_NEG_BIT = 1'b1;
    localparam logic MAP_POS_BIT = 1'b0;

    // Reference sample for phase n; SPS=8 uses the fixed table, other sizes are computed.
    function automatic logic signed [REF_W-1:0] ref_lut(ref_sel_e sel, int unsigned n,
                                                        int unsigned sps);
        logic signed [REF_W-1:0] cos_t [8];
        logic signed [REF_W-1:0] sin_t [8];
        real ang;
        real val;
        cos_t = '{8'sd127, 8'sd90, 8'sd0, -8'sd90, -8'sd127, -8'sd90, 8'sd0, 8'sd90};
        sin_t = '{8'sd0, 8'sd90, 8'sd127, 8'sd90, 8'sd0, -8'sd90, -8'sd127, -8'sd90};
        if (sps == 8) begin
            return (sel == REF_COS) ? cos_t[n % 8] : sin_t[n % 8];
        end
        ang = 2.0 * 3.14159265358979 * $itor(n) / $itor(sps);
        val = (sel == REF_COS) ? $itor(REF_FS) * $cos(ang) : $itor(REF_FS) * $sin(ang);
        val = (val >= 0.0) ? val + 0.5 : val - 0.5;
        return REF_W'($rtoi(val));
    endfunction

endpackage

// File: rtl/qam_correlator.sv
// Multiplies each accepted sample by one carrier reference and integrates over a symbol.
module qam_correlator
    import qam_pkg::*;
#(
    parameter ref_sel_e    SEL      = REF_COS,
    parameter int unsigned SPS      = qam_pkg::SPS,
    parameter int unsigned SAMPLE_W = qam_pkg::SAMPLE_W,
    parameter int unsigned REF_W    = qam_pkg::REF_W,
    parameter int unsigned ACC_W    = SAMPLE_W + REF_W + $clog2(SPS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       en,
    input  logic                       restart,
    input  logic [$clog2(SPS)-1:0]     phase,
    output logic signed [ACC_W-1:0]    acc_next
);

    localparam int unsigned PROD_W = SAMPLE_W + REF_W;

    logic signed [REF_W-1:0]  lut [SPS];
    logic signed [REF_W-1:0]  ref_val;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;

    for (genvar g = 0; g < SPS; g++) begin : g_lut
        assign lut[g] = ref_lut(SEL, g, SPS);
    end

    // Full-precision product and restart-or-accumulate next value.
    always_comb begin
        ref_val = lut[phase];
        prod    = sample_in * ref_val;
        acc_d   = acc_q;
        if (en) begin
            acc_d = restart ? ACC_W'(prod) : acc_q + ACC_W'(prod);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Slicer needs the value including the sample being integrated this cycle.
    assign acc_next = acc_d;

endmodule

// File: rtl/qam4_demod.sv
// 4-QAM receive demodulator: phase tracking, I/Q correlation and sign slicing.
module qam4_demod
    import qam_pkg::*;
#(
    parameter int unsigned SPS      = qam_pkg::SPS,
    parameter int unsigned SAMPLE_W = qam_pkg::SAMPLE_W,
    parameter int unsigned REF_W    = qam_pkg::REF_W,
    parameter int unsigned ACC_W    = SAMPLE_W + REF_W + $clog2(SPS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic                       sym_sync,
    output logic [1:0]                 data_out,
    output logic                       data_valid,
    output logic [$clog2(SPS)-1:0]     phase
);

    localparam int unsigned PHASE_W = $clog2(SPS);

    logic [PHASE_W-1:0]      phase_d, phase_q;
    logic [1:0]              data_out_d, data_out_q;
    logic                    data_valid_d, data_valid_q;
    logic [PHASE_W-1:0]      ref_phase;
    logic                    restart;
    logic signed [ACC_W-1:0] acc_i_next;
    logic signed [ACC_W-1:0] acc_q_next;

    qam_correlator #(
        .SEL      (REF_COS),
        .SPS      (SPS),
        .SAMPLE_W (SAMPLE_W),
        .REF_W    (REF_W),
        .ACC_W    (ACC_W)
    ) u_corr_i (
        .clk       (clk),
        .rst_n     (rst),
        .sample_in (sample_in),
        .en        (sample_valid),
        .restart   (restart),
        .phase     (ref_phase),
        .acc_next  (acc_i_next)
    );

    qam_correlator #(
        .SEL      (REF_SIN),
        .SPS      (SPS),
        .SAMPLE_W (SAMPLE_W),
        .REF_W    (REF_W),
        .ACC_W    (ACC_W)
    ) u_corr_q (
        .clk       (clk),
        .rst_n     (rst),
        .sample_in (sample_in),
        .en        (sample_valid),
        .restart   (restart),
        .phase     (ref_phase),
        .acc_next  (acc_q_next)
    );

    // Phase advance, sync override and end-of-symbol slicing.
    always_comb begin
        phase_d      = phase_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        // A sync sample is phase 0 regardless of the counter.
        ref_phase    = sym_sync ? '0 : phase_q;
        restart      = sym_sync || (phase_q == '0);
        if (sample_valid) begin
            if (sym_sync) begin
                phase_d = PHASE_W'(1);
            end else begin
                phase_d = phase_q + 1'b1;
                if (phase_q == PHASE_W'(SPS - 1)) begin
                    data_valid_d = 1'b1;
                    data_out_d   = {acc_i_next[ACC_W-1] ? MAP_NEG_BIT : MAP_POS_BIT,
                                    acc_q_next[ACC_W-1] ? MAP_NEG_BIT : MAP_POS_BIT};
                end
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_qam4_demod.sv
// Directed self-checking bench for qam4_demod.
module tb_qam4_demod;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic signed [7:0] sample_in = '0;
    logic              sample_valid = 1'b0;
    logic              sym_sync = 1'b0;
    logic [1:0]        data_out;
    logic              data_valid;
    logic [2:0]        phase;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_cap = 0;
    int stable_err = 0;
    logic [1:0] prev_out = '0;

    int COS [8] = '{127, 90, 0, -90, -127, -90, 0, 90};
    int SIN [8] = '{0, 90, 127, 90, 0, -90, -127, -90};

    typedef struct {
        int         cyc;
        logic [1:0] d;
    } pulse_t;
    pulse_t pq [$];

    qam4_demod dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sym_sync     (sym_sync),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .phase        (phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record pulses and note any data_out change without a pulse.
    always @(negedge clk) begin
        if (rst && data_valid) pq.push_back('{cyc, data_out});
        if (rst && !data_valid && data_out !== prev_out) stable_err++;
        prev_out = data_out;
    end

    function automatic int mod_sample(int sym, int n);
        int i_amp;
        int q_amp;
        i_amp = ((sym >> 1) & 1) != 0 ? -63 : 63;
        q_amp = (sym & 1) != 0 ? -63 : 63;
        return (i_amp * COS[n] + q_amp * SIN[n]) >>> 7;
    endfunction

    task automatic drive(input int s, input logic v, input logic sy);
        sample_in    = 8'(s);
        sample_valid = v;
        sym_sync     = sy;
        @(posedge clk);
        #1;
        if (v) last_cap = cyc;
        sample_valid = 1'b0;
        sym_sync     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #3;
        checks++;
        if (phase !== 3'd0 || data_out !== 2'b00 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got ph=%0d d=%b v=%b want ph=0 d=00 v=0", phase, data_out, data_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
    endtask

    task automatic test_back_to_back;
        int c0;
        pq.delete();
        for (int s = 0; s < 4; s++)
            for (int n = 0; n < 8; n++) begin
                sample_in    = 8'(mod_sample(s, n));
                sample_valid = 1'b1;
                sym_sync     = (s == 0 && n == 0);
                @(posedge clk);
                #1;
                if (s == 0 && n == 0) c0 = cyc;
            end
        sample_valid = 1'b0;
        sym_sync     = 1'b0;
        idle(2);
        checks++;
        if (pq.size() !== 4) begin
            errors++;
            $display("FAIL b2b_count got %0d want 4", pq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (pq[k].d !== 2'(k)) begin
                    errors++;
                    $display("FAIL b2b_data[%0d] got %b want %b", k, pq[k].d, 2'(k));
                end
                checks++;
                if (pq[k].cyc - c0 !== 8 * k + 7) begin
                    errors++;
                    $display("FAIL b2b_time[%0d] got %0d want %0d", k, pq[k].cyc - c0, 8 * k + 7);
                end
            end
        end
        checks++;
        if (phase !== 3'd0) begin
            errors++;
            $display("FAIL b2b_phase got %0d want 0", phase);
        end
    endtask

    task automatic test_gapped;
        pq.delete();
        stable_err = 0;
        for (int s = 0; s < 4; s++)
            for (int n = 0; n < 8; n++) begin
                drive(mod_sample(s, n), 1'b1, s == 0 && n == 0);
                idle(1);
            end
        idle(2);
        checks++;
        if (pq.size() !== 4) begin
            errors++;
            $display("FAIL gap_count got %0d want 4", pq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (pq[k].d !== 2'(k)) begin
                    errors++;
                    $display("FAIL gap_data[%0d] got %b want %b", k, pq[k].d, 2'(k));
                end
                if (k > 0) begin
                    checks++;
                    if (pq[k].cyc - pq[k-1].cyc !== 16) begin
                        errors++;
                        $display("FAIL gap_spacing[%0d] got %0d want 16", k, pq[k].cyc - pq[k-1].cyc);
                    end
                end
            end
        end
        checks++;
        if (stable_err !== 0) begin
            errors++;
            $display("FAIL gap_hold got %0d changes want 0", stable_err);
        end
    endtask

    task automatic test_zero;
        pq.delete();
        for (int i = 0; i < 24; i++) drive(0, 1'b1, i == 0);
        idle(2);
        checks++;
        if (pq.size() !== 3) begin
            errors++;
            $display("FAIL zero_count got %0d want 3", pq.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (pq[k].d !== 2'b00) begin
                    errors++;
                    $display("FAIL zero_data[%0d] got %b want 00", k, pq[k].d);
                end
            end
        end
    endtask

    task automatic test_resync;
        pq.delete();
        for (int n = 0; n < 5; n++) drive(mod_sample(3, n), 1'b1, n == 0);
        for (int n = 0; n < 8; n++) drive(mod_sample(2, n), 1'b1, n == 0);
        idle(2);
        checks++;
        if (pq.size() !== 1) begin
            errors++;
            $display("FAIL resync_count got %0d want 1", pq.size());
        end else begin
            checks++;
            if (pq[0].d !== 2'b10) begin
                errors++;
                $display("FAIL resync_data got %b want 10", pq[0].d);
            end
            checks++;
            if (pq[0].cyc !== last_cap) begin
                errors++;
                $display("FAIL resync_time got %0d want %0d", pq[0].cyc, last_cap);
            end
        end
        checks++;
        if (phase !== 3'd0) begin
            errors++;
            $display("FAIL resync_phase got %0d want 0", phase);
        end
    endtask

    task automatic test_reset_mid;
        pq.delete();
        for (int n = 0; n < 4; n++) drive(mod_sample(1, n), 1'b1, n == 0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (data_out !== 2'b00 || data_valid !== 1'b0 || phase !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset got d=%b v=%b ph=%0d want d=00 v=0 ph=0", data_out, data_valid, phase);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        for (int n = 0; n < 8; n++) drive(mod_sample(3, n), 1'b1, 1'b0);
        idle(2);
        checks++;
        if (pq.size() !== 1) begin
            errors++;
            $display("FAIL mid_count got %0d want 1", pq.size());
        end else begin
            checks++;
            if (pq[0].d !== 2'b11) begin
                errors++;
                $display("FAIL mid_data got %b want 11", pq[0].d);
            end
        end
    endtask

    task automatic test_fullscale;
        int exp_i;
        int exp_q;
        logic signed [18:0] act_i;
        logic signed [18:0] act_q;
        // -128 at every phase
        pq.delete();
        exp_i = 0;
        exp_q = 0;
        for (int n = 0; n < 8; n++) begin
            drive(-128, 1'b1, n == 0);
            exp_i += -128 * COS[n];
            exp_q += -128 * SIN[n];
        end
        idle(2);
        act_i = dut.u_corr_i.acc_q;
        act_q = dut.u_corr_q.acc_q;
        checks++;
        if (act_i !== 19'(exp_i) || act_q !== 19'(exp_q)) begin
            errors++;
            $display("FAIL fs_acc got i=%0d q=%0d want i=%0d q=%0d", act_i, act_q, exp_i, exp_q);
        end
        checks++;
        if (pq.size() !== 1 || data_out !== 2'b00) begin
            errors++;
            $display("FAIL fs_data got n=%0d d=%b want n=1 d=00", pq.size(), data_out);
        end
        // -128 only at phase 0: large negative I, zero Q
        pq.delete();
        exp_i = 0;
        exp_q = 0;
        for (int n = 0; n < 8; n++) begin
            drive(n == 0 ? -128 : 0, 1'b1, n == 0);
            exp_i += (n == 0 ? -128 : 0) * COS[n];
            exp_q += (n == 0 ? -128 : 0) * SIN[n];
        end
        idle(2);
        act_i = dut.u_corr_i.acc_q;
        act_q = dut.u_corr_q.acc_q;
        checks++;
        if (act_i !== 19'(exp_i) || act_q !== 19'(exp_q)) begin
            errors++;
            $display("FAIL fs1_acc got i=%0d q=%0d want i=%0d q=%0d", act_i, act_q, exp_i, exp_q);
        end
        checks++;
        if (pq.size() !== 1 || data_out !== 2'b10) begin
            errors++;
            $display("FAIL fs1_data got n=%0d d=%b want n=1 d=10", pq.size(), data_out);
        end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_gapped;
        test_zero;
        test_resync;
        test_reset_mid;
        test_fullscale;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
